// File: rtl/burst_sram_pkg.sv
// Shared types and constants for the burst_sram memory device:
// the burst state enum, default bus widths and the parity helper.
package burst_sram_pkg;

  localparam int ADD_WIDTH    = 12;
  localparam int DATA_WIDTH   = 8;
  localparam int BLEN_WIDTH   = 4;
  localparam int PARITY_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  // Even parity: the returned bit makes the total count of ones even.
  // Callers zero-extend narrower words, which leaves the result unchanged.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/burst_sram_if.sv
// Command and status signals of the burst_sram bus; the shared data bus
// stays a plain inout port on the device so tristate resolution is module-level.
interface burst_sram_if
  import burst_sram_pkg::*;
#(
  parameter int add_width  = ADD_WIDTH,
  parameter int blen_width = BLEN_WIDTH
);

  logic                  cs;
  logic                  we;
  logic                  oe;
  logic [add_width-1:0]  addr;
  logic [blen_width-1:0] blen;
  logic                  busy;
  logic                  rd_valid;
  logic                  err;
  logic                  perr;

  modport master (
    output cs, we, oe, addr, blen,
    input  busy, rd_valid, err, perr
  );

  modport slave (
    input  cs, we, oe, addr, blen,
    output busy, rd_valid, err, perr
  );

endinterface

// File: rtl/sram_array.sv
// Single-port synchronous RAM: one access per cycle, write-enable and
// read-enable share the address, and the read word is registered.
module sram_array #(
  parameter int depth  = 4096,
  parameter int width  = 8,
  parameter int addr_w = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [addr_w-1:0] addr,
  input  logic [width-1:0]  wdata,
  output logic [width-1:0]  rdata
);

  logic [width-1:0] mem [depth];

  // Storage and read register are data, so neither is reset; rdata holds
  // its last beat until the next read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/burst_sram.sv
// Burst-capable single-port SRAM on a shared cs/we/oe/addr/data bus.
// Optional even-parity storage and checking is enabled by BURST_SRAM_PARITY_EN.
module burst_sram
  import burst_sram_pkg::*;
#(
  parameter int add_width  = ADD_WIDTH,
  parameter int data_width = DATA_WIDTH,
  parameter int depth      = 4096,
  parameter int blen_width = BLEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  burst_sram_if.slave           bus,
  inout  wire  [data_width-1:0] data
);

  localparam int mem_aw = (depth > 1) ? $clog2(depth) : 1;
`ifdef BURST_SRAM_PARITY_EN
  localparam int store_w = data_width + 1;
`else
  localparam int store_w = data_width;
`endif
  localparam logic [add_width-1:0]  last_addr = add_width'(depth - 1);
  localparam logic [add_width:0]    depth_lim = (add_width + 1)'(depth);
  localparam logic [blen_width-1:0] one_beat  = blen_width'(1);

  state_t                state, state_nxt;
  logic [add_width-1:0]  ptr, ptr_nxt, acc_addr;
  logic [blen_width-1:0] beats_left, beats_nxt;
  logic                  wr_en, rd_en, err_nxt;
  logic                  rd_valid, err_q;
  logic [store_w-1:0]    wdata, rdata;

  function automatic logic [add_width-1:0] inc_ptr(input logic [add_width-1:0] p);
    return (p == last_addr) ? '0 : p + add_width'(1);
  endfunction

  // The first beat is served straight from the command address; later beats
  // come from ptr, which always points at the next beat to transfer.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    beats_nxt = beats_left;
    acc_addr  = ptr;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cs) begin
          acc_addr = bus.addr;
          if ({1'b0, bus.addr} >= depth_lim) begin
            err_nxt = 1'b1;
          end else begin
            wr_en     = bus.we;
            rd_en     = !bus.we;
            ptr_nxt   = inc_ptr(bus.addr);
            beats_nxt = bus.blen;
            if (bus.blen != '0) begin
              state_nxt = bus.we ? WR_BURST : RD_BURST;
            end
          end
        end
      end
      WR_BURST, RD_BURST: begin
        wr_en     = (state == WR_BURST);
        rd_en     = (state == RD_BURST);
        ptr_nxt   = inc_ptr(ptr);
        beats_nxt = beats_left - one_beat;
        if (beats_left == one_beat) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A reset edge aborts the burst before its beat touches memory.
    if (rst) begin
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      beats_left <= '0;
      rd_valid   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      beats_left <= beats_nxt;
      rd_valid   <= rd_en;
      err_q      <= err_nxt;
    end
  end

  // ---- storage stage: one beat per edge, read word lands in rdata ----
  sram_array #(
    .depth  (depth),
    .width  (store_w),
    .addr_w (mem_aw)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .re    (rd_en),
    .addr  (acc_addr[mem_aw-1:0]),
    .wdata (wdata),
    .rdata (rdata)
  );

  // ---- output stage: status, parity check and bus drive ----
`ifdef BURST_SRAM_PARITY_EN
  assign wdata    = {even_parity(PARITY_MAX_W'(data)), data};
  assign bus.perr = rd_valid &&
                    (even_parity(PARITY_MAX_W'(rdata[data_width-1:0])) != rdata[data_width]);
`else
  assign wdata    = data;
  assign bus.perr = 1'b0;
`endif

  assign bus.busy     = (state != IDLE);
  assign bus.rd_valid = rd_valid;
  assign bus.err      = err_q;

  assign data = (bus.oe && rd_valid) ? rdata[data_width-1:0] : {data_width{1'bz}};

endmodule
